// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display path: active-low 7-segment
// patterns ({g,f,e,d,c,b,a}) and the digit-scan state encoding.
package scoreboard_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes
// (0xA..0xF) show a dash so corrupted scores are visible on the board.
module bcd_to_seg7
    import scoreboard_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous capture,
// inter-digit blanking and leading-zero suppression. Optional SEG_BLINK_EN.
module seg7_display_driver
    import scoreboard_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int BLINK_DIV_LOG2 = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_blank,
    input  logic                      blink,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic                      frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_E = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    scan_state_e               state_q;

    logic [4*NUM_DIGITS-1:0]   shadow_bcd_q;
    logic [NUM_DIGITS-1:0]     shadow_dp_q;
    logic [4*NUM_DIGITS-1:0]   act_bcd_q;
    logic [NUM_DIGITS-1:0]     act_dp_q;

    logic [NUM_DIGITS-1:0]     an_d;
    logic [6:0]                seg_d;
    logic                      dp_d;

    logic                      slot_end;
    logic                      frame_end;
    logic                      blink_off;
    logic [3:0]                act_digit [NUM_DIGITS];
    logic [3:0]                sel_bcd;
    logic [6:0]                dec_seg;
    logic [NUM_DIGITS-1:0]     suppress;
    logic                      higher_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign act_digit[g] = act_bcd_q[4*g +: 4];
    end

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    assign idx_d     = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    assign sel_bcd   = act_digit[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i   (sel_bcd),
        .seg_n_o (dec_seg)
    );

    // A digit is suppressed when it and every digit above it are zero; a lit
    // decimal point keeps that one digit visible.
    always_comb begin
        suppress    = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero & (act_digit[i] == 4'd0);
            suppress[i] = lz_blank & higher_zero & ~act_dp_q[i];
        end
    end

`ifdef SEG_BLINK_EN
    logic [BLINK_DIV_LOG2-1:0] blink_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
        end else if (blink) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end else begin
            blink_cnt_q <= '0;
        end
    end

    assign blink_off = blink_cnt_q[BLINK_DIV_LOG2-1];
`else
    localparam int unused_blink_w = BLINK_DIV_LOG2;
    logic unused_blink;
    assign unused_blink = blink;
    assign blink_off    = 1'b0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == ON && !suppress[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~act_dp_q[idx_q];
        end
        if (blink_off) begin
            an_d = '1;
        end
    end

    // Scan FSM plus registered pin drivers; pins lag the scan state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= BLANK;
            an_n       <= '1;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            case (state_q)
                BLANK:   if (cnt_q == CNT_BLANK_E) state_q <= ON;
                ON:      if (slot_end)             state_q <= BLANK;
                default:                           state_q <= BLANK;
            endcase
            an_n       <= an_d;
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            frame_tick <= frame_end;
        end
    end

    // Active digits only change at the frame boundary, so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '0;
        end else begin
            if (load) begin
                shadow_bcd_q <= bcd_in;
                shadow_dp_q  <= dp_in;
            end
            if (frame_end) begin
                act_bcd_q <= load ? bcd_in : shadow_bcd_q;
                act_dp_q  <= load ? dp_in  : shadow_dp_q;
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed bench for seg7_display_driver with a 4-digit, 8-cycle-slot,
// 2-cycle-blank configuration; honours SEG_BLINK_EN when defined.
module tb_seg7_display_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;
    localparam int ON_CYC = RD - BC;

    localparam logic [6:0] P0    = 7'b1000000;
    localparam logic [6:0] P1    = 7'b1111001;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P4    = 7'b0011001;
    localparam logic [6:0] P5    = 7'b0010010;
    localparam logic [6:0] P7    = 7'b1111000;
    localparam logic [6:0] PDASH = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic        blink = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    int         on_cnt [4];
    logic [6:0] seg_seen [4];
    logic [3:0] dp_seen;
    int         multi_low;
    int         tear;
    int         lit_cycles;
    int         ft_cnt;

    always #5 clk = ~clk;

    seg7_display_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .BLINK_DIV_LOG2 (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .blink      (blink),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int zeros(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic load_val(input logic [15:0] v, input logic [3:0] dpv);
        bcd_in = v;
        dp_in  = dpv;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_frame;
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 2 * FRAME);
        check("wait_frame_tick", frame_tick, 1);
    endtask

    // Observes one full frame, starting right after a frame_tick sample.
    // load_at > 0 pulses load so the DUT samples it on that edge of the frame.
    task automatic scan_frame(input int load_at, input logic [15:0] v, input logic [3:0] dpv);
        int z;
        int idx;
        for (int i = 0; i < 4; i++) begin
            on_cnt[i]   = 0;
            seg_seen[i] = 7'h7F;
        end
        dp_seen = '0;
        multi_low = 0;
        tear = 0;
        lit_cycles = 0;
        ft_cnt = 0;
        for (int j = 1; j <= FRAME; j++) begin
            if (j == load_at) begin
                bcd_in = v;
                dp_in  = dpv;
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            if (frame_tick) ft_cnt++;
            z = zeros(an_n);
            if (z > 1) multi_low++;
            if (z == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (an_n[i] == 1'b0) idx = i;
                lit_cycles++;
                if (on_cnt[idx] == 0) begin
                    seg_seen[idx] = seg_n;
                    dp_seen[idx]  = ~dp_n;
                end else if (seg_seen[idx] !== seg_n || dp_seen[idx] !== ~dp_n) begin
                    tear++;
                end
                on_cnt[idx]++;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int bad_gap;
        int last;
        int lat;
        int total_lit;
        int total_ft;

        // Reset state
        tick(); tick(); tick();
        check("rst_an_n", an_n, 4'hF);
        check("rst_seg_n", seg_n, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_frame_tick", frame_tick, 1'b0);

        // First load appears at the next frame
        reset = 1'b0;
        load_val(16'h1234, 4'h0);
        wait_frame();
        scan_frame(0, '0, '0);
        check("t1_d0_on_cycles", on_cnt[0], ON_CYC);
        check("t1_d0_seg", seg_seen[0], P4);
        check("t1_d1_seg", seg_seen[1], P3);
        check("t1_d3_seg", seg_seen[3], P1);
        check("t1_dp_off", dp_seen, 4'h0);
        check("t1_frame_ticks", ft_cnt, 1);

        // Free run: 10 frame ticks, 32 cycles apart, one anode at a time
        pulses = 0; bad_gap = 0; last = 0; multi_low = 0;
        for (int c = 1; c <= 320; c++) begin
            tick();
            if (zeros(an_n) > 1) multi_low++;
            if (frame_tick) begin
                pulses++;
                if (c - last != FRAME) bad_gap++;
                last = c;
            end
        end
        check("t2_pulses", pulses, 10);
        check("t2_gap", bad_gap, 0);
        check("t2_multi_anode", multi_low, 0);

        // Leading-zero suppression
        lz_blank = 1'b1;
        load_val(16'h0007, 4'h0);
        wait_frame();
        scan_frame(0, '0, '0);
        check("t3_7_d0_cycles", on_cnt[0], ON_CYC);
        check("t3_7_upper_lit", on_cnt[1] + on_cnt[2] + on_cnt[3], 0);
        check("t3_7_seg", seg_seen[0], P7);
        load_val(16'h0000, 4'h0);
        wait_frame();
        scan_frame(0, '0, '0);
        check("t3_0_d0_cycles", on_cnt[0], ON_CYC);
        check("t3_0_seg", seg_seen[0], P0);
        check("t3_0_upper_lit", on_cnt[1] + on_cnt[2] + on_cnt[3], 0);
        load_val(16'h0000, 4'b0100);
        wait_frame();
        scan_frame(0, '0, '0);
        check("t3_dp_d2_cycles", on_cnt[2], ON_CYC);
        check("t3_dp_d2_seg", seg_seen[2], P0);
        check("t3_dp_d2_dp", dp_seen[2], 1'b1);
        check("t3_dp_d1_d3_lit", on_cnt[1] + on_cnt[3], 0);
        lz_blank = 1'b0;

        // Frame-synchronous capture
        load_val(16'h1234, 4'h0);
        wait_frame();
        scan_frame(20, 16'h5555, 4'h0);
        check("t4_d2_old", seg_seen[2], P2);
        check("t4_d3_old", seg_seen[3], P1);
        check("t4_no_tear", tear, 0);
        scan_frame(FRAME, 16'h00A0, 4'h0);
        check("t4_5555_d0", seg_seen[0], P5);
        check("t4_5555_d3", seg_seen[3], P5);
        check("t4_5555_tear", tear, 0);
        scan_frame(0, '0, '0);
        check("t4_boundary_d1_dash", seg_seen[1], PDASH);
        check("t4_boundary_d0", seg_seen[0], P0);
        check("t4_boundary_d2", seg_seen[2], P0);

        // Blink
        blink = 1'b1;
        scan_frame(0, '0, '0);
        total_lit = lit_cycles;
        total_ft  = ft_cnt;
        scan_frame(0, '0, '0);
        total_lit += lit_cycles;
        total_ft  += ft_cnt;
        blink = 1'b0;
`ifdef SEG_BLINK_EN
        check("t5_blink_lit", total_lit, 24);
`else
        check("t5_blink_ignored_lit", total_lit, 2 * ND * ON_CYC);
`endif
        check("t5_blink_ticks", total_ft, 2);

        // Asynchronous reset mid-ON of digit 2, then restart from digit 0
        wait_frame();
        for (int j = 0; j < 20; j++) tick();
        check("t6_pre_d2_on", an_n, 4'b1011);
        #2 reset = 1'b1;
        #1;
        check("t6_async_an_n", an_n, 4'hF);
        check("t6_async_seg_n", seg_n, 7'h7F);
        check("t6_async_dp_n", dp_n, 1'b1);
        check("t6_async_tick", frame_tick, 1'b0);
        tick(); tick();
        reset = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (an_n == 4'hF && lat < 4 * FRAME);
        check("t6_first_anode", an_n, 4'b1110);
        check("t6_first_lit_latency", lat, BC + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
